io_ctrl: RTL
============

# io_ctrl

Memory-mapped IO controller for the SoC's IO window. It sits directly downstream of the address space splitter and consumes its `io_*` bus (address, bidirectional data, read/write strobes, ready). It provides four 32-bit registers: LED control, a free-running cycle counter, a timer compare value and a timer status flag. It also drives the board `status_led`, either directly or as a hardware-blinked heartbeat.

## Interface
- `ADDR_WIDTH`, 32, IO address bus width
- `DATA_WIDTH`, 32, IO data bus width (must be ≥ `CLOCK_DIV_WIDTH`)
- `CLOCK_DIV_WIDTH`, 25, width of timer counter and compare register
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `io_addr`  in  `ADDR_WIDTH`  byte address from splitter
- `io_data`  inout  `DATA_WIDTH`  write data from CPU; read data driven by this block only during read acknowledge, high-Z otherwise
- `io_read`  in  1  read request, held by master until `io_ready`
- `io_write`  in  1  write request, held by master until `io_ready`
- `io_ready`  out  1  one-cycle transaction acknowledge
- `status_led`  out  1  board LED, equals LED register bit 0

## Operation
- Register map:
  - Decode uses `io_addr[3:2]`.
  - `io_addr[7:4]` nonzero selects unmapped space: reads return 0, writes are ignored, `io_ready` is still given.
  - Bits above 7 and bits [1:0] are ignored.
- 0x0 LED: bit0 = LED value, bit1 = blink enable; other bits read 0. Read/write.
- 0x4 CYCLES: 32-bit free-running counter, +1 every cycle, wraps 0xFFFFFFFF→0. Writes are ignored.
- 0x8 COMPARE: `CLOCK_DIV_WIDTH` bits, zero-extended on read. Read/write.
- 0xC STATUS: bit0 = tick flag. Writing 1 to bit0 clears it; writing 0 has no effect.
- Timer:
  - Counter `div` counts 0..COMPARE.
  - On the cycle `div == COMPARE`: `div` returns to 0, tick flag sets, and if blink is enabled, LED bit0 toggles.
  - COMPARE = 0 disables the timer: `div` is held at 0, no ticks.
  - A write to COMPARE also clears `div` to 0.
- Bus FSM states:
  - IDLE: if `io_write` is high, perform the register write this edge and go to ACK. Else if `io_read` is high, capture read data and go to ACK.
  - ACK: `io_ready` = 1. On a read, drive `io_data` with the captured value. Go to WAIT.
  - WAIT: `io_ready` = 0, `io_data` high-Z. Return to IDLE once `io_read` and `io_write` are both low.
- `io_read` and `io_write` both high: treated as a write; no read data driven.
- Simultaneous events:
  - Tick set vs software clear in the same cycle: set wins.
  - Hardware toggle vs software LED write in the same cycle: software write wins.
- Reset values:
  - `io_ready` = 0, `io_data` = Z, FSM = IDLE.
  - LED = 0b10 (blink enabled, LED off), `status_led` = 0.
  - CYCLES = 0, `div` = 0, COMPARE = all ones, tick = 0.
- Reset asserted mid-transaction: FSM returns to IDLE and `io_ready`/`io_data` release at the next edge. A request still held after reset is serviced as a new one.

## Timing
- Request first seen high in IDLE at edge N:
  - A write takes effect at edge N.
  - `io_ready` is high for exactly one cycle, from edge N+1 to edge N+2.
- Read data is the register value sampled at edge N and is valid on `io_data` while `io_ready` is high.
  - CYCLES therefore reads as the count at edge N.
- Minimum spacing between back-to-back requests is 3 cycles: IDLE→ACK→WAIT→IDLE, with strobes low for at least one edge.
- `status_led` is a registered output; it changes at the same edge as LED bit0.
- With COMPARE = C > 0, tick period and blink half-period are C+1 cycles.

## Test plan
- Reset, then read 0x0, 0x8 and 0xC → 0x2, 0x01FFFFFF and 0x0. `io_ready` pulses exactly one cycle per read; `io_data` is Z outside the ACK cycle.
- Write LED = 0x1 → `status_led` = 1 from edge N; read back 0x1; LED remains steady over 100 cycles (blink off).
- Write COMPARE = 3, LED = 0x2 → tick flag sets and `status_led` toggles every 4 cycles. Write STATUS = 1 → flag reads 0 until the next tick. A clear issued on the tick cycle leaves the flag at 1.
- Read CYCLES twice, 10 cycles apart between request edges → difference is exactly 10. Force the counter near 0xFFFFFFFF → wraps to 0.
- Read 0x10 and write 0x14 → read returns 0, ready is given, no register changes. `io_read`+`io_write` both high to 0x0 → write performed and `io_data` not driven.
- Hold `io_write` high for 5 cycles → exactly one write and one ready pulse. Assert `rst` during ACK → `io_ready` = 0 next cycle and all registers return to reset values.

Source files
------------

// File: rtl/io_bus_if.sv
// IO window bus from the address splitter: address, strobes and acknowledge.
// The bidirectional data lines stay a plain inout port on the controller so the
// tristate driver lives in one place.
interface io_bus_if #(
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] io_addr;
   logic                  io_read;
   logic                  io_write;
   logic                  io_ready;

   modport master (output io_addr, output io_read, output io_write, input io_ready);
   modport slave  (input io_addr, input io_read, input io_write, output io_ready);
endinterface

// File: rtl/io_ctrl.sv
// Memory-mapped IO controller: LED, free-running cycle counter, timer compare
// and timer tick flag, plus the board status LED with optional hardware blink.
module io_ctrl #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int CLOCK_DIV_WIDTH = 25
) (
   input  logic                  clk,
   input  logic                  rst,
   io_bus_if.slave               bus,
   inout  wire  [DATA_WIDTH-1:0] io_data,
   output logic                  status_led
);

   typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

   state_t                     state_q, state_d;
   logic                       ready_d, ready_q;
   logic                       drv_d, drv_q;
   logic                       rd_q;
   logic [DATA_WIDTH-1:0]      rdata_d, rdata_q;

   logic [1:0]                 led_q;
   logic [31:0]                cycles_q;
   logic [CLOCK_DIV_WIDTH-1:0] compare_q;
   logic [CLOCK_DIV_WIDTH-1:0] div_q;
   logic                       tick_q;

   logic       mapped;
   logic [1:0] sel;
   logic       wr_en, rd_en, tick_evt;

   // Address bits above 7 and the byte offset are don't-care.
   assign mapped   = (bus.io_addr[7:4] == 4'h0);
   assign sel      = bus.io_addr[3:2];
   // A write has priority over a simultaneous read.
   assign wr_en    = (state_q == IDLE) && bus.io_write;
   assign rd_en    = (state_q == IDLE) && !bus.io_write && bus.io_read;
   assign tick_evt = (compare_q != '0) && (div_q == compare_q);

   assign bus.io_ready = ready_q;
   assign io_data      = drv_q ? rdata_q : 'z;
   assign status_led   = led_q[0];

   // Bus FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Bus FSM next state: one ACK cycle, then wait for the master to drop strobes.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.io_write || bus.io_read) state_d = ACK;
         ACK:     state_d = WAIT;
         WAIT:    if (!bus.io_write && !bus.io_read) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus FSM outputs, registered below so ready and data release cleanly on reset.
   always_comb begin
      ready_d = (state_q == ACK);
      drv_d   = (state_q == ACK) && rd_q;
   end

   // Output flops for the acknowledge and the data driver enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q <= 1'b0;
         drv_q   <= 1'b0;
      end else begin
         ready_q <= ready_d;
         drv_q   <= drv_d;
      end
   end

   // Read mux; unmapped space and unused bits read as zero.
   always_comb begin
      rdata_d = '0;
      if (mapped) begin
         case (sel)
            2'd0: rdata_d[1:0] = led_q;
            2'd1: rdata_d      = DATA_WIDTH'(cycles_q);
            2'd2: rdata_d      = DATA_WIDTH'(compare_q);
            2'd3: rdata_d[0]   = tick_q;
            default: rdata_d   = '0;
         endcase
      end
   end

   // Capture read data and transaction type at the request edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q    <= 1'b0;
         rdata_q <= '0;
      end else if (state_q == IDLE) begin
         rd_q <= rd_en;
         if (rd_en) rdata_q <= rdata_d;
      end
   end

   // Register file and timer; software LED write beats hardware toggle,
   // hardware tick beats software clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         led_q     <= 2'b10;
         cycles_q  <= '0;
         compare_q <= '1;
         div_q     <= '0;
         tick_q    <= 1'b0;
      end else begin
         cycles_q <= cycles_q + 32'd1;

         if (wr_en && mapped && sel == 2'd0) led_q <= io_data[1:0];
         else if (tick_evt && led_q[1])      led_q[0] <= ~led_q[0];

         if (wr_en && mapped && sel == 2'd2) compare_q <= io_data[CLOCK_DIV_WIDTH-1:0];

         if ((wr_en && mapped && sel == 2'd2) || compare_q == '0 || tick_evt) div_q <= '0;
         else                                                                div_q <= div_q + 1'b1;

         if (tick_evt)                                      tick_q <= 1'b1;
         else if (wr_en && mapped && sel == 2'd3 && io_data[0]) tick_q <= 1'b0;
      end
   end

endmodule
